// File: rtl/avalon_pio_pkg.sv
// Shared definitions for the Avalon-MM input PIO: register map and bus width.
package avalon_pio_pkg;

  localparam int BUS_W = 32;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RAW      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;

endpackage

// File: rtl/avalon_pio_in_edge_if.sv
// Avalon-MM slave bus of the input PIO, including its level interrupt.
interface avalon_pio_in_edge_if;
  import avalon_pio_pkg::*;

  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [BUS_W-1:0] writedata;
  logic [BUS_W-1:0] readdata;
  logic             irq;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

endinterface

// File: rtl/pio_in_filter_bit.sv
// One input bit: synchroniser chain, debounce counter and stable value,
// with single-cycle rise/fall pulses in the cycle the stable value flips.
module pio_in_filter_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  input  logic prime_i,
  output logic raw_o,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int DC = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1;
  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stable_q, stable_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   differ, flip;

  assign raw_o    = sync_q[SYNC_STAGES-1];
  assign stable_o = stable_q;
  assign differ   = raw_o ^ stable_q;
  // Flip on the DC-th consecutive disagreeing cycle; never while priming.
  assign flip     = ~prime_i & differ & (cnt_q == CNT_LAST);
  assign rise_o   = flip & raw_o;
  assign fall_o   = flip & ~raw_o;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (prime_i || flip) begin
      stable_d = raw_o;
      cnt_d    = '0;
    end else if (differ) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], in_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/avalon_pio_in_edge.sv
// Parametrised Avalon-MM input PIO with debounce, selectable edge capture
// (write-1-to-clear) and a registered level interrupt.
module avalon_pio_in_edge
  import avalon_pio_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 0,
  parameter logic [WIDTH-1:0] RISE_EN_RESET   = '1,
  parameter logic [WIDTH-1:0] FALL_EN_RESET   = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  avalon_pio_in_edge_if.slave        bus,
  input  logic [WIDTH-1:0]           in_port
);

  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIME_LOAD = PW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] raw, data, rise, fall, event_v, clr, wdata;
  logic [WIDTH-1:0] mask_q, mask_d, edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [BUS_W-1:0] readdata_d;
  logic [PW-1:0]    prime_q, prime_d;
  logic             priming, wr, irq_d;
  logic             unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  // Priming covers the synchroniser fill so inputs high at reset raise no edge.
  assign priming = (prime_q != '0);
  assign prime_d = priming ? prime_q - 1'b1 : prime_q;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    pio_in_filter_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filt (
      .clk      (clk),
      .reset    (reset),
      .in_i     (in_port[b]),
      .prime_i  (priming),
      .raw_o    (raw[b]),
      .stable_o (data[b]),
      .rise_o   (rise[b]),
      .fall_o   (fall[b])
    );
  end

  always_comb begin
    event_v   = (rise & rise_en_q) | (fall & fall_en_q);
    clr       = (wr && bus.address == ADDR_EDGE_CAP) ? wdata : '0;
    // A new event outranks a simultaneous clear of the same bit.
    edge_cap_d = (edge_cap_q & ~clr) | event_v;
    mask_d    = (wr && bus.address == ADDR_IRQ_MASK) ? wdata : mask_q;
    rise_en_d = (wr && bus.address == ADDR_RISE_EN)  ? wdata : rise_en_q;
    fall_en_d = (wr && bus.address == ADDR_FALL_EN)  ? wdata : fall_en_q;
    irq_d     = |(edge_cap_q & mask_q);
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:     readdata_d = BUS_W'(data);
      ADDR_RAW:      readdata_d = BUS_W'(raw);
      ADDR_IRQ_MASK: readdata_d = BUS_W'(mask_q);
      ADDR_EDGE_CAP: readdata_d = BUS_W'(edge_cap_q);
      ADDR_RISE_EN:  readdata_d = BUS_W'(rise_en_q);
      ADDR_FALL_EN:  readdata_d = BUS_W'(fall_en_q);
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prime_q      <= PRIME_LOAD;
      mask_q       <= '0;
      edge_cap_q   <= '0;
      rise_en_q    <= RISE_EN_RESET;
      fall_en_q    <= FALL_EN_RESET;
      bus.readdata <= '0;
      bus.irq      <= 1'b0;
    end else begin
      prime_q      <= prime_d;
      mask_q       <= mask_d;
      edge_cap_q   <= edge_cap_d;
      rise_en_q    <= rise_en_d;
      fall_en_q    <= fall_en_d;
      bus.readdata <= readdata_d;
      bus.irq      <= irq_d;
    end
  end

endmodule

// File: tb/tb_avalon_pio_in_edge.sv
// Bench for the input PIO: two instances (debounce 0 and 4) share one stimulus
// and are compared every cycle against a history-based model of the register map.
module tb_avalon_pio_in_edge;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int DEFF [2] = '{1, 4};

  logic        clk, reset;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;

  int nchk = 0;
  int nerr = 0;

  avalon_pio_in_edge_if bus0 ();
  avalon_pio_in_edge_if bus4 ();

  assign bus0.address = address;  assign bus4.address = address;
  assign bus0.chipselect = chipselect;  assign bus4.chipselect = chipselect;
  assign bus0.write_n = write_n;  assign bus4.write_n = write_n;
  assign bus0.writedata = writedata;  assign bus4.writedata = writedata;

  avalon_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .in_port(in_port));
  avalon_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .in_port(in_port));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [W-1:0] hist [0:4095];
  int           ecnt = 0;
  int           rst_edge = 0;
  bit           mvalid = 0;
  logic [W-1:0] m_stable [2], m_cap [2], m_mask [2], m_rise [2], m_fall [2];
  int           m_streak [2][W];
  logic [31:0]  m_rd [2];
  logic         m_irq [2];

  // Synchroniser output after edge n: the input seen SS-1 edges earlier, zero if that predates reset.
  function automatic logic [W-1:0] raw_after(int n);
    int src = n - (SS - 1);
    if (src <= rst_edge) return '0;
    return hist[src % 4096];
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] rp, ev, clr;
    bit prime, wr;
    ecnt++;
    hist[ecnt % 4096] = in_port;
    if (reset) begin
      rst_edge = ecnt;
      mvalid   = 1;
      for (int i = 0; i < 2; i++) begin
        m_stable[i] = '0; m_cap[i] = '0; m_mask[i] = '0;
        m_rise[i] = '1; m_fall[i] = '0; m_rd[i] = '0; m_irq[i] = 1'b0;
        for (int b = 0; b < W; b++) m_streak[i][b] = 0;
      end
    end else begin
      rp    = raw_after(ecnt - 1);
      prime = (ecnt <= rst_edge + SS + 1);
      wr    = chipselect && !write_n;
      for (int i = 0; i < 2; i++) begin
        case (address)
          3'd0: m_rd[i] = {24'd0, m_stable[i]};
          3'd1: m_rd[i] = {24'd0, rp};
          3'd2: m_rd[i] = {24'd0, m_mask[i]};
          3'd3: m_rd[i] = {24'd0, m_cap[i]};
          3'd4: m_rd[i] = {24'd0, m_rise[i]};
          3'd5: m_rd[i] = {24'd0, m_fall[i]};
          default: m_rd[i] = '0;
        endcase
        m_irq[i] = |(m_cap[i] & m_mask[i]);
        ev = '0;
        for (int b = 0; b < W; b++) begin
          if (prime) begin
            m_stable[i][b] = rp[b];
            m_streak[i][b] = 0;
          end else if (rp[b] != m_stable[i][b]) begin
            m_streak[i][b]++;
            if (m_streak[i][b] == DEFF[i]) begin
              m_stable[i][b] = rp[b];
              m_streak[i][b] = 0;
              ev[b] = rp[b] ? m_rise[i][b] : m_fall[i][b];
            end
          end else begin
            m_streak[i][b] = 0;
          end
        end
        clr = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
        m_cap[i] = (m_cap[i] & ~clr) | ev;
        if (wr && address == 3'd2) m_mask[i] = writedata[W-1:0];
        if (wr && address == 3'd4) m_rise[i] = writedata[W-1:0];
        if (wr && address == 3'd5) m_fall[i] = writedata[W-1:0];
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("rd0_model", bus0.readdata, m_rd[0]);
      chk("irq0_model", {31'd0, bus0.irq}, {31'd0, m_irq[0]});
      chk("rd4_model", bus4.readdata, m_rd[1]);
      chk("irq4_model", {31'd0, bus4.irq}, {31'd0, m_irq[1]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [7:0] e0, input logic [7:0] e4);
    address = a;
    tick(1);
    chk({nm, "_d0"}, bus0.readdata, {24'd0, e0});
    chk({nm, "_d4"}, bus4.readdata, {24'd0, e4});
  endtask

  initial begin
    reset = 1'b1; in_port = 8'hFF; address = 3'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    tick(3);
    chk("reset_rd", bus0.readdata, 32'd0);
    chk("reset_irq", {31'd0, bus4.irq}, 32'd0);

    // Inputs already high across reset: no spurious edge.
    reset = 1'b0;
    tick(5);
    chk("prime_data0", bus0.readdata, 32'hFF);
    chk("prime_data4", bus4.readdata, 32'hFF);
    rd_chk("prime_cap", 3'd3, 8'h00, 8'h00);
    chk("prime_irq", {31'd0, bus0.irq}, 32'd0);

    // Rising edge on bit0 with D=0, mask bit0.
    in_port = 8'h00;
    tick(8);
    wr_reg(3'd2, 32'h01);
    address = 3'd3; in_port = 8'h01;
    tick(1);                       // edge 0
    tick(1);                       // edge 1
    tick(1);                       // edge 2
    chk("model_cap_e2", {24'd0, m_cap[0]}, 32'h01);
    chk("cap_e2_rd", bus0.readdata, 32'h00);
    chk("irq_e2", {31'd0, bus0.irq}, 32'd0);
    tick(1);                       // edge 3
    chk("cap_e3_rd", bus0.readdata, 32'h01);
    chk("irq_e3", {31'd0, bus0.irq}, 32'd1);
    wr_reg(3'd3, 32'h01);
    chk("irq_w1c_p1", {31'd0, bus0.irq}, 32'd1);
    tick(1);
    chk("irq_w1c_p2", {31'd0, bus0.irq}, 32'd0);
    tick(8);
    wr_reg(3'd3, 32'hFF);
    tick(2);

    // D=4: a 3-cycle glitch is filtered, a 4-cycle pulse passes.
    in_port = 8'h05; tick(3);
    in_port = 8'h01; tick(10);
    rd_chk("glitch_data", 3'd0, 8'h01, 8'h01);
    rd_chk("glitch_cap", 3'd3, 8'h04, 8'h00);
    address = 3'd0;
    in_port = 8'h05; tick(4);      // edges 0..3
    in_port = 8'h01; tick(1);      // edge 4
    tick(1);                       // edge 5
    chk("model_stable_e5", {24'd0, m_stable[1]}, 32'h05);
    chk("pulse_data_e5", bus4.readdata, 32'h01);
    tick(1);                       // edge 6
    chk("pulse_data_e6", bus4.readdata, 32'h05);
    tick(10);
    rd_chk("pulse_cap", 3'd3, 8'h04, 8'h04);
    wr_reg(3'd3, 32'hFF);
    tick(2);

    // Falling-edge-only capture on bit3.
    wr_reg(3'd4, 32'h00);
    wr_reg(3'd5, 32'h08);
    in_port = 8'h09; tick(8);
    rd_chk("fall_after_rise", 3'd3, 8'h00, 8'h00);
    in_port = 8'h01; tick(8);
    rd_chk("fall_after_fall", 3'd3, 8'h08, 8'h08);
    wr_reg(3'd4, 32'hFF);
    wr_reg(3'd5, 32'h00);
    wr_reg(3'd3, 32'hFF);
    tick(2);

    // W1C colliding with an event on the same bit.
    in_port = 8'h03; tick(2);      // edges 0,1
    address = 3'd3; writedata = 32'h02; chipselect = 1'b1; write_n = 1'b0;
    tick(1);                       // edge 2: event and clear together
    chipselect = 1'b0; write_n = 1'b1;
    chk("model_cap_collide", {24'd0, m_cap[0]}, 32'h02);
    tick(1);
    chk("cap_collide", bus0.readdata, 32'h02);
    tick(6);
    in_port = 8'h23; tick(8);
    rd_chk("cap_b1b5", 3'd3, 8'h22, 8'h22);
    wr_reg(3'd3, 32'h02);
    rd_chk("cap_keep_b5", 3'd3, 8'h20, 8'h20);

    // Reset mid-debounce with captures pending.
    in_port = 8'h00; tick(8);
    wr_reg(3'd3, 32'hFF);
    in_port = 8'hA5; tick(8);
    rd_chk("cap_a5", 3'd3, 8'hA5, 8'hA5);
    in_port = 8'h5A; tick(2);
    reset = 1'b1; tick(1);
    chk("midrst_rd0", bus0.readdata, 32'd0);
    chk("midrst_rd4", bus4.readdata, 32'd0);
    chk("midrst_irq", {31'd0, bus4.irq}, 32'd0);
    reset = 1'b0;
    rd_chk("rst_cap", 3'd3, 8'h00, 8'h00);
    rd_chk("rst_mask", 3'd2, 8'h00, 8'h00);
    rd_chk("rst_rise", 3'd4, 8'hFF, 8'hFF);
    rd_chk("rst_fall", 3'd5, 8'h00, 8'h00);
    tick(4);
    rd_chk("rst_data", 3'd0, 8'h5A, 8'h5A);
    rd_chk("rst_cap_after", 3'd3, 8'h00, 8'h00);
    rd_chk("rst_addr7", 3'd7, 8'h00, 8'h00);
    chk("rst_irq_after", {31'd0, bus0.irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
